// File: rtl/ddr_phy_pkg.sv
// Shared types for the DFI write-side traffic scheduler.
package ddr_phy_pkg;

   localparam int TRF_NUM_CH = 4;

   typedef enum logic [1:0] {
      TRF_CA  = 2'd0,
      TRF_CK  = 2'd1,
      TRF_DQ  = 2'd2,
      TRF_DQS = 2'd3
   } ddr_trf_ch_t;

   typedef enum logic [1:0] {
      TRF_IDLE   = 2'd0,
      TRF_WARM   = 2'd1,
      TRF_ACTIVE = 2'd2,
      TRF_COOL   = 2'd3
   } ddr_trf_st_t;

endpackage

// File: rtl/ddr_trf_chan_fsm.sv
// One traffic group: warm-up / active / cool-down sequencer with a shared down-counter.
module ddr_trf_chan_fsm
   import ddr_phy_pkg::*;
#(
   parameter int PRE_W  = 4,
   parameter int POST_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              eff_i,
   input  logic [PRE_W-1:0]  pre_i,
   input  logic [POST_W-1:0] post_i,
   output logic              en_o,
   output logic              rdy_o
);

   localparam int CNT_W = (PRE_W > POST_W) ? PRE_W : POST_W;

   ddr_trf_st_t      st_q;
   logic [CNT_W-1:0] cnt_q;
   logic             en_q;
   logic             rdy_q;
   logic [CNT_W-1:0] pre_m1;
   logic [CNT_W-1:0] post_m1;
   logic             pre_zero;
   logic             post_zero;

   // Reload values are only consumed on state entry, so CSR changes land on the next entry.
   assign pre_zero  = (pre_i == {PRE_W{1'b0}});
   assign post_zero = (post_i == {POST_W{1'b0}});
   assign pre_m1    = CNT_W'(pre_i) - {{(CNT_W-1){1'b0}}, 1'b1};
   assign post_m1   = CNT_W'(post_i) - {{(CNT_W-1){1'b0}}, 1'b1};

   // Group state machine; en/rdy are registered alongside the state they decode.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q  <= TRF_IDLE;
         cnt_q <= {CNT_W{1'b0}};
         en_q  <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         case (st_q)
            TRF_IDLE: begin
               if (eff_i) begin
                  en_q <= 1'b1;
                  if (pre_zero) begin
                     st_q  <= TRF_ACTIVE;
                     rdy_q <= 1'b1;
                  end else begin
                     st_q  <= TRF_WARM;
                     cnt_q <= pre_m1;
                  end
               end
            end
            TRF_WARM: begin
               // Warm-up always runs to completion even if the request drops.
               if (cnt_q != {CNT_W{1'b0}}) begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end else if (eff_i) begin
                  st_q  <= TRF_ACTIVE;
                  rdy_q <= 1'b1;
               end else if (post_zero) begin
                  st_q <= TRF_IDLE;
                  en_q <= 1'b0;
               end else begin
                  st_q  <= TRF_COOL;
                  cnt_q <= post_m1;
                  rdy_q <= 1'b1;
               end
            end
            TRF_ACTIVE: begin
               if (!eff_i) begin
                  if (post_zero) begin
                     st_q  <= TRF_IDLE;
                     en_q  <= 1'b0;
                     rdy_q <= 1'b0;
                  end else begin
                     st_q  <= TRF_COOL;
                     cnt_q <= post_m1;
                  end
               end
            end
            TRF_COOL: begin
               if (eff_i) begin
                  st_q <= TRF_ACTIVE;
               end else if (cnt_q != {CNT_W{1'b0}}) begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  st_q  <= TRF_IDLE;
                  en_q  <= 1'b0;
                  rdy_q <= 1'b0;
               end
            end
            default: begin
               st_q  <= TRF_IDLE;
               cnt_q <= {CNT_W{1'b0}};
               en_q  <= 1'b0;
               rdy_q <= 1'b0;
            end
         endcase
      end
   end

   assign en_o  = en_q;
   assign rdy_o = rdy_q;

endmodule

// File: rtl/ddr_dfi_traffic_sched.sv
// Sequences CA/CK/DQ/DQS traffic groups; CA keeps CK alive and DQ keeps DQS alive.
module ddr_dfi_traffic_sched
   import ddr_phy_pkg::*;
#(
   parameter int PRE_W  = 4,
   parameter int POST_W = 6
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [TRF_NUM_CH-1:0]          i_req,
   input  logic [TRF_NUM_CH-1:0]          i_force_on,
   input  logic                           i_gate_dis,
   input  logic [TRF_NUM_CH*PRE_W-1:0]    i_pre_cyc,
   input  logic [TRF_NUM_CH*POST_W-1:0]   i_post_cyc,
   output logic [TRF_NUM_CH-1:0]          o_en,
   output logic [TRF_NUM_CH-1:0]          o_rdy,
   output logic                           o_busy
);

   logic [TRF_NUM_CH-1:0] eff_req;
   logic [TRF_NUM_CH-1:0] fsm_en;
   logic [TRF_NUM_CH-1:0] fsm_rdy;

   // Effective per-group request: clock groups follow their traffic partners.
   always_comb begin
      eff_req                 = i_req;
      eff_req[int'(TRF_CK)]   = i_req[int'(TRF_CK)] | i_req[int'(TRF_CA)];
      eff_req[int'(TRF_DQS)]  = i_req[int'(TRF_DQS)] | i_req[int'(TRF_DQ)];
      eff_req                 = eff_req | i_force_on;
   end

   for (genvar g = 0; g < TRF_NUM_CH; g++) begin : g_chan
      ddr_trf_chan_fsm #(
         .PRE_W  (PRE_W),
         .POST_W (POST_W)
      ) u_fsm (
         .clk_i  (i_clk),
         .rst_ni (i_rst_n),
         .eff_i  (eff_req[g]),
         .pre_i  (i_pre_cyc[g*PRE_W +: PRE_W]),
         .post_i (i_post_cyc[g*POST_W +: POST_W]),
         .en_o   (fsm_en[g]),
         .rdy_o  (fsm_rdy[g])
      );
   end

   // Gate-disable overrides only the outputs; the FSMs keep tracking requests.
   assign o_en   = fsm_en  | {TRF_NUM_CH{i_gate_dis}};
   assign o_rdy  = fsm_rdy | {TRF_NUM_CH{i_gate_dis}};
   assign o_busy = |fsm_en;

endmodule

// File: tb/tb_ddr_dfi_traffic_sched.sv
// Scoreboard bench for ddr_dfi_traffic_sched: per-cycle expected outputs queued at drive time.
module tb_ddr_dfi_traffic_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_v;
   logic [3:0]  frc_v;
   logic        gd_v;
   logic [15:0] pre_v;
   logic [23:0] post_v;
   logic [3:0]  o_en;
   logic [3:0]  o_rdy;
   logic        o_busy;

   logic [3:0]  obs_en;
   logic [3:0]  obs_rdy;
   logic [8:0]  sb[$];
   int          m_st[4];
   int          m_cnt[4];
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   ddr_dfi_traffic_sched dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req_v),
      .i_force_on (frc_v),
      .i_gate_dis (gd_v),
      .i_pre_cyc  (pre_v),
      .i_post_cyc (post_v),
      .o_en       (o_en),
      .o_rdy      (o_rdy),
      .o_busy     (o_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic set_timing(input int g, input int pre, input int post);
      pre_v[g*4 +: 4]  = 4'(pre);
      post_v[g*6 +: 6] = 6'(post);
   endtask

   task automatic model_reset();
      for (int g = 0; g < 4; g++) begin
         m_st[g]  = 0;
         m_cnt[g] = 0;
      end
   endtask

   // States: 0 idle, 1 warm, 2 active, 3 cool.
   task automatic run_cycle(input logic [3:0] req, input logic [3:0] frc, input logic gd,
                            input string tag);
      logic [3:0] e_en, e_rdy, eff;
      logic [8:0] exp_v;
      int pre, post;
      req_v = req;
      frc_v = frc;
      gd_v  = gd;
      for (int g = 0; g < 4; g++) begin
         e_en[g]  = (m_st[g] != 0);
         e_rdy[g] = (m_st[g] >= 2);
      end
      exp_v = {|e_en, gd ? 4'hF : e_en, gd ? 4'hF : e_rdy};
      sb.push_back(exp_v);
      @(negedge clk);
      obs_en  = o_en;
      obs_rdy = o_rdy;
      check_eq(tag, 32'({o_busy, o_en, o_rdy}), 32'(sb.pop_front()));
      eff    = req;
      eff[1] = req[1] | req[0];
      eff[3] = req[3] | req[2];
      eff    = eff | frc;
      for (int g = 0; g < 4; g++) begin
         pre  = int'(pre_v[g*4 +: 4]);
         post = int'(post_v[g*6 +: 6]);
         case (m_st[g])
            0: if (eff[g]) begin
                  if (pre == 0) m_st[g] = 2;
                  else begin m_st[g] = 1; m_cnt[g] = pre - 1; end
               end
            1: if (m_cnt[g] != 0) m_cnt[g]--;
               else if (eff[g]) m_st[g] = 2;
               else if (post == 0) m_st[g] = 0;
               else begin m_st[g] = 3; m_cnt[g] = post - 1; end
            2: if (!eff[g]) begin
                  if (post == 0) m_st[g] = 0;
                  else begin m_st[g] = 3; m_cnt[g] = post - 1; end
               end
            default: if (eff[g]) m_st[g] = 2;
               else if (m_cnt[g] != 0) m_cnt[g]--;
               else m_st[g] = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      req_v  = 4'd0;
      frc_v  = 4'd0;
      gd_v   = 1'b0;
      pre_v  = 16'd0;
      post_v = 24'd0;
      set_timing(0, 3, 5);
      set_timing(1, 2, 4);
      set_timing(2, 0, 0);
      set_timing(3, 1, 3);
      model_reset();
      #12;
      check_eq("reset_out", 32'({o_busy, o_en, o_rdy}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // CA basic: request cycles 10-19
      for (int c = 0; c < 30; c++) begin
         run_cycle({3'b000, 1'(c >= 10 && c <= 19)}, 4'd0, 1'b0, "ca_basic");
         if (c == 10) check_eq("ca_en_c10", 32'(obs_en[0]), 32'd0);
         if (c == 11) check_eq("ca_en_c11", 32'(obs_en[0]), 32'd1);
         if (c == 13) check_eq("ca_rdy_c13", 32'(obs_rdy[0]), 32'd0);
         if (c == 14) check_eq("ca_rdy_c14", 32'(obs_rdy[0]), 32'd1);
         if (c == 25) check_eq("ca_en_c25", 32'(obs_en[0]), 32'd1);
         if (c == 26) check_eq("ca_en_c26", 32'(obs_en[0]), 32'd0);
         if (c == 13) check_eq("ck_rdy_c13", 32'(obs_rdy[1]), 32'd1);
         if (c == 24) check_eq("ck_en_c24", 32'(obs_en[1]), 32'd1);
         if (c == 25) check_eq("ck_en_c25", 32'(obs_en[1]), 32'd0);
      end

      // Zero timing on DQ, single-cycle request
      for (int c = 0; c < 20; c++) begin
         run_cycle({1'b0, 1'(c == 10), 2'b00}, 4'd0, 1'b0, "dq_zero");
         if (c == 11) check_eq("dq_en_rdy_c11", 32'({obs_en[2], obs_rdy[2], obs_en[3]}), 32'd7);
         if (c == 12) check_eq("dq_en_rdy_c12", 32'({obs_en[2], obs_rdy[2]}), 32'd0);
      end

      // Request drop during warm-up
      set_timing(0, 7, 2);
      for (int c = 0; c < 25; c++) begin
         run_cycle({3'b000, 1'(c == 10)}, 4'd0, 1'b0, "warm_drop");
         if (c == 17) check_eq("wd_c17", 32'({obs_en[0], obs_rdy[0]}), 32'd2);
         if (c == 18) check_eq("wd_c18", 32'({obs_en[0], obs_rdy[0]}), 32'd3);
         if (c == 19) check_eq("wd_c19", 32'({obs_en[0], obs_rdy[0]}), 32'd3);
         if (c == 20) check_eq("wd_c20", 32'({obs_en[0], obs_rdy[0]}), 32'd0);
      end

      // Re-request during cool-down
      set_timing(0, 3, 6);
      for (int c = 0; c < 45; c++) begin
         run_cycle({3'b000, 1'((c >= 10 && c <= 19) || (c >= 23 && c <= 29))}, 4'd0, 1'b0,
                   "cool_rereq");
         if (c >= 14 && c <= 36)
            check_eq("rr_hold", 32'({obs_en[0], obs_rdy[0]}), 32'd3);
         if (c == 37) check_eq("rr_c37", 32'(obs_en[0]), 32'd0);
      end

      // Force-on and gate-disable overrides
      for (int c = 0; c < 35; c++) begin
         run_cycle(4'd0, {2'b00, 1'(c < 25), 1'b0}, 1'(c == 12), "override");
         if (c == 10) check_eq("force_ck_en", 32'(obs_en), 32'h2);
         if (c == 12) check_eq("gate_dis_on", 32'({obs_en, obs_rdy}), 32'hFF);
         if (c == 13) check_eq("gate_dis_off", 32'({obs_en, obs_rdy}), 32'h22);
      end

      // Asynchronous reset while CA is active
      set_timing(0, 3, 5);
      for (int c = 0; c < 20; c++) run_cycle(4'b0001, 4'd0, 1'b0, "pre_rst");
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_out", 32'({o_busy, o_en, o_rdy}), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         run_cycle({3'b000, 1'(c >= 5 && c <= 8)}, 4'd0, 1'b0, "post_rst");
         if (c == 5) check_eq("post_rst_idle", 32'(obs_en), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
